m_btn_debounce: RTL and testbench

M_BTN_DEBOUNCE -- requirements
Module: m_btn_debounce

---
 rtl/m_btn_debounce.sv | 155 +++++++++++++++
 tb/tb_m_btn_debounce.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_btn_debounce.sv
// ----------------------------------------------------------------------------
// m_btn_debounce
//
// Multi-channel push-button / switch debouncer with edge pulses, per-channel
// toggle state and a shared press counter.
//
// Each raw input bit is brought into the w_clk domain through a two-flop
// synchronizer. Behind that, a per-channel stability counter measures how
// long the synchronized sample has disagreed with the accepted level. Once it
// has disagreed for DEB_CYCLES consecutive samples, the new level is accepted.
// A glitch back to the accepted level before then restarts the count from 0.
//
// Parameters
//   DEB_CYCLES  consecutive stable synchronized samples needed to accept a new
//               level (2 .. 2^24-1)
//   NCH         number of independent channels
//
// Ports
//   w_clk       system clock, all state moves on its rising edge
//   w_rst_n     asynchronous active-low reset, clears every flop
//   w_btn       raw asynchronous button inputs, one bit per channel
//   w_level     debounced level per channel
//   w_press     one-cycle pulse on each accepted 0->1 transition
//   w_release   one-cycle pulse on each accepted 1->0 transition
//   w_toggle    per-channel state that flips on every press
//   w_count     modulo-256 count of accepted presses over all channels
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module m_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned NCH        = 4
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    input  logic [NCH-1:0] w_btn,
    output logic [NCH-1:0] w_level,
    output logic [NCH-1:0] w_press,
    output logic [NCH-1:0] w_release,
    output logic [NCH-1:0] w_toggle,
    output logic [7:0]     w_count
);

    // Counter only ever has to hold DEB_CYCLES-1.
    localparam int unsigned    CntW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [NCH-1:0]           sync1_q,   sync1_d;
    logic [NCH-1:0]           sync2_q,   sync2_d;
    logic [NCH-1:0][CntW-1:0] cnt_q,     cnt_d;
    logic [NCH-1:0]           level_q,   level_d;
    logic [NCH-1:0]           press_q,   press_d;
    logic [NCH-1:0]           release_q, release_d;
    logic [NCH-1:0]           toggle_q,  toggle_d;
    logic [7:0]               count_q,   count_d;
    logic [7:0]               press_sum;

    // ------------------------------------------------------------------------
    // Synchronizer: the only logic that looks at w_btn.
    // ------------------------------------------------------------------------
    always_comb begin
        sync1_d = w_btn;
        sync2_d = sync1_q;
    end

    // ------------------------------------------------------------------------
    // Per-channel qualification and edge generation.
    // Channels share nothing here, so one channel can never disturb another.
    // ------------------------------------------------------------------------
    always_comb begin
        level_d   = level_q;
        toggle_d  = toggle_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    // Disagreement has lasted long enough: accept it now.
                    // Pulses are computed here so they are registered
                    // alongside the level they describe.
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                    toggle_d[i]  = toggle_q[i] ^ sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // Agreement leaves cnt_d at 0, so partial counts never accumulate.
        end
    end

    // ------------------------------------------------------------------------
    // Press counter: adds the number of channels pressing this cycle, so
    // simultaneous presses are all counted. 8-bit wrap is intentional.
    // ------------------------------------------------------------------------
    always_comb begin
        press_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            press_sum = press_sum + 8'(press_d[i]);
        end
        count_d = count_q + press_sum;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            toggle_q  <= '0;
            count_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from flops.
    // ------------------------------------------------------------------------
    assign w_level   = level_q;
    assign w_press   = press_q;
    assign w_release = release_q;
    assign w_toggle  = toggle_q;
    assign w_count   = count_q;

`ifndef SYNTHESIS
    // A channel cannot both rise and fall in one cycle.
    a_press_release_excl : assert property (@(posedge w_clk) disable iff (!w_rst_n)
        (w_press & w_release) == '0);

    // A press pulse always accompanies a high level, a release a low one.
    a_press_level : assert property (@(posedge w_clk) disable iff (!w_rst_n)
        (w_press & ~w_level) == '0);
    a_release_level : assert property (@(posedge w_clk) disable iff (!w_rst_n)
        (w_release & w_level) == '0);
`endif

endmodule

// File: tb/tb_m_btn_debounce.sv
// ----------------------------------------------------------------------------
// tb_m_btn_debounce
//
// Directed bench for m_btn_debounce with DEB_CYCLES=4, NCH=4.
// Stimulus pushes the expected pulse (cycle, press/release vectors, level,
// toggle and the count seen one cycle later) into a queue; an independent
// monitor pops an entry whenever the DUT shows a press or release pulse.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_m_btn_debounce;

    localparam int unsigned DEB = 4;
    localparam int unsigned NCH = 4;
    // Edge on which an accepted change appears, counted from the drive point.
    localparam int unsigned LAT = DEB + 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] btn;
    logic [NCH-1:0] level;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] toggle;
    logic [7:0]     count;

    m_btn_debounce #(
        .DEB_CYCLES(DEB),
        .NCH       (NCH)
    ) dut (
        .w_clk    (clk),
        .w_rst_n  (rst_n),
        .w_btn    (btn),
        .w_level  (level),
        .w_press  (press),
        .w_release(rel),
        .w_toggle (toggle),
        .w_count  (count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  level;
        logic [3:0]  toggle;
        logic [7:0]  count;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the accepted levels / toggles / count.
    logic [3:0] m_level  = '0;
    logic [3:0] m_toggle = '0;
    logic [7:0] m_count  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_event(input logic [3:0] p, input logic [3:0] r, input int unsigned at);
        exp_t e;
        m_level  = (m_level | p) & ~r;
        m_toggle = m_toggle ^ p;
        for (int i = 0; i < 4; i++) m_count = m_count + 8'(p[i]);
        e.cyc    = at;
        e.press  = p;
        e.rel    = r;
        e.level  = m_level;
        e.toggle = m_toggle;
        e.count  = m_count;
        exp_q.push_back(e);
    endtask

    // Clean level change on any subset of channels, then let it settle.
    task automatic drive(input logic [3:0] v);
        logic [3:0] p;
        logic [3:0] r;
        p   = v & ~btn;
        r   = ~v & btn;
        btn = v;
        if ((p | r) != '0) push_event(p, r, cyc + LAT);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   32'(level),  32'h0);
        check({tag, "_press"},   32'(press),  32'h0);
        check({tag, "_release"}, 32'(rel),    32'h0);
        check({tag, "_toggle"},  32'(toggle), 32'h0);
        check({tag, "_count"},   32'(count),  32'h0);
    endtask

    // Assert reset mid-cycle, hold for two edges, release just after an edge.
    task automatic pulse_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
        m_level  = '0;
        m_toggle = '0;
        m_count  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if ((press | rel) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {24'h0, press, rel}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle",   cyc,            e.cyc);
                    check("pulse_press",   32'(press),     32'(e.press));
                    check("pulse_release", 32'(rel),       32'(e.rel));
                    check("pulse_level",   32'(level),     32'(e.level));
                    check("pulse_toggle",  32'(toggle),    32'(e.toggle));
                    @(negedge clk);
                    check("pulse_width",   {24'h0, press, rel}, 32'h0);
                    check("pulse_count",   32'(count),     32'(e.count));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : stimulus
        int unsigned wait_cnt;
        rst_n = 1'b0;
        btn   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Clean press on channel 0.
        drive(4'b0001);
        check("clean_level",  32'(level),  32'h1);
        check("clean_toggle", 32'(toggle), 32'h1);
        check("clean_count",  32'(count),  32'd1);

        // Bounce on channel 1: high 3, low 1, then high stable.
        btn[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn[1] = 1'b0;
        @(posedge clk);
        #1;
        btn[1] = 1'b1;
        push_event(4'b0010, 4'b0000, cyc + LAT);
        repeat (10) @(posedge clk);
        #1;
        check("bounce_count", 32'(count), 32'd2);

        // Press then release on channel 2.
        drive(4'b0111);
        drive(4'b0011);
        check("release_level",  32'(level),  32'h3);
        check("release_toggle", 32'(toggle), 32'h7);
        check("release_count",  32'(count),  32'd3);

        // Bring count to 254 from a clean reset, then press all four at once.
        drive(4'b0000);
        pulse_reset("rst_a");
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 63; k++) begin
            drive(4'b1111);
            drive(4'b0000);
        end
        drive(4'b0011);
        drive(4'b0000);
        check("pre_wrap_count", 32'(count), 32'd254);
        drive(4'b1111);
        check("wrap_count",  32'(count),  32'd2);
        check("wrap_toggle", 32'(toggle), 32'h3);
        drive(4'b0000);

        // Reset in the middle of qualifying channel 3.
        btn = 4'b1000;
        repeat (3) @(posedge clk);
        pulse_reset("rst_mid");
        push_event(4'b1000, 4'b0000, cyc + LAT);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_level",  32'(level),  32'h8);
        check("post_rst_toggle", 32'(toggle), 32'h8);
        check("post_rst_count",  32'(count),  32'd1);

        // Two full press/release cycles on channel 0 from reset.
        drive(4'b0000);
        @(posedge clk);
        pulse_reset("rst_b");
        repeat (3) @(posedge clk);
        #1;
        check("rep_toggle0_a", 32'(toggle[0]), 32'd0);
        drive(4'b0001);
        check("rep_toggle0_b", 32'(toggle[0]), 32'd1);
        drive(4'b0000);
        drive(4'b0001);
        check("rep_toggle0_c", 32'(toggle[0]), 32'd0);
        drive(4'b0000);
        check("rep_count", 32'(count), 32'd2);

        // Every queued pulse must have been seen.
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("pending_events", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
